// File: rtl/impact_pkg.sv
// Shared types and widths for the IMPACT SRAM head control path.
// Used by the access sequencer and the head/bank decoders.
package impact_pkg;

  localparam int WORD_W = 10;
  localparam int BANK_W = 2;
  localparam int BYTE_W = 2;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;
  localparam int TMR_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PRE,
    ST_ACC,
    ST_CAP,
    ST_NEXT
  } seq_state_e;

  typedef struct packed {
    logic              write;
    logic [WORD_W-1:0] word;
    logic [BANK_W-1:0] bank;
    logic [BYTE_W-1:0] byte_sel;
  } sram_req_t;

  // A phase lasting N cycles starts the timer at N-1 so done rises in its last cycle.
  function automatic logic [TMR_W-1:0] tmr_preset(input int cycles);
    return TMR_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/sram_access_sequencer_seq_timer.sv
// Loadable down-counter shared by the precharge, access and capture phases.
// Holds at zero; o_done is high whenever the count is zero.
module seq_timer
  import impact_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/sram_access_sequencer.sv
// Host-request to IMPACT SRAM head pin sequencer: precharge, access, capture per beat,
// with one outstanding single/burst request and read-byte return under backpressure.
module sram_access_sequencer
  import impact_pkg::*;
#(
  parameter int PRE_CYCLES = 2,
  parameter int ACC_CYCLES = 2,
  parameter int MUX_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_word,
  input  logic [BANK_W-1:0] req_bank,
  input  logic [BYTE_W-1:0] req_byte,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic [WORD_W-1:0] sram_word_sel,
  output logic [BANK_W-1:0] sram_bank_sel,
  output logic [BYTE_W-1:0] sram_byte_sel,
  output logic [DATA_W-1:0] sram_data_in,
  output logic              sram_precharge,
  output logic              sram_read_en,
  output logic              sram_write_en,
  input  logic [DATA_W-1:0] sram_data_out
);

  // state | meaning
  // IDLE  | waiting for a host request
  // SETUP | selects driven; write beats wait here for the data byte
  // PRE   | precharge held for PRE_CYCLES
  // ACC   | read or write enable held for ACC_CYCLES
  // CAP   | read only: wait for the out-mux, hold the byte until consumed
  // NEXT  | retire beat, advance word or return to IDLE

  seq_state_e        r_state;
  seq_state_e        w_next_state;
  sram_req_t         r_req;
  logic [LEN_W-1:0]  r_beats;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_valid;
  logic              r_rsp_last;
  logic              r_ready_en;

  logic              w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_value;
  logic              w_tmr_done;
  logic              w_req_fire;
  logic              w_wd_fire;
  logic              w_rsp_fire;
  logic              w_capture;

  seq_timer #(
    .W (TMR_W)
  ) u_seq_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_value),
    .o_done  (w_tmr_done)
  );

  assign w_req_fire = req_valid & req_ready;
  assign w_wd_fire  = wd_valid & wd_ready;
  assign w_rsp_fire = r_rsp_valid & rsp_ready;
  assign w_capture  = (r_state == ST_CAP) & w_tmr_done & ~r_rsp_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_tmr_load   = 1'b0;
    w_tmr_value  = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req_fire) begin
          w_next_state = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (!r_req.write || wd_valid) begin
          w_next_state = ST_PRE;
          w_tmr_load   = 1'b1;
          w_tmr_value  = tmr_preset(PRE_CYCLES);
        end
      end
      ST_PRE: begin
        if (w_tmr_done) begin
          w_next_state = ST_ACC;
          w_tmr_load   = 1'b1;
          w_tmr_value  = tmr_preset(ACC_CYCLES);
        end
      end
      ST_ACC: begin
        if (w_tmr_done) begin
          if (r_req.write) begin
            w_next_state = ST_NEXT;
          end else begin
            w_next_state = ST_CAP;
            w_tmr_load   = 1'b1;
            w_tmr_value  = tmr_preset(MUX_LAT);
          end
        end
      end
      ST_CAP: begin
        if (w_rsp_fire) begin
          w_next_state = ST_NEXT;
        end
      end
      ST_NEXT: begin
        w_next_state = (r_beats == '0) ? ST_IDLE : ST_SETUP;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Pin enables decode straight from state so a reset drops them on the very next edge.
  always_comb begin
    req_ready      = 1'b0;
    wd_ready       = 1'b0;
    sram_precharge = 1'b0;
    sram_read_en   = 1'b0;
    sram_write_en  = 1'b0;
    busy           = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        req_ready = r_ready_en;
        busy      = 1'b0;
      end
      ST_SETUP: begin
        wd_ready = r_req.write;
      end
      ST_PRE: begin
        sram_precharge = 1'b1;
      end
      ST_ACC: begin
        sram_read_en  = ~r_req.write;
        sram_write_en = r_req.write;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_req       <= '0;
      r_beats     <= '0;
      r_wdata     <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_ready_en  <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_req_fire) begin
        r_req <= '{write: req_write, word: req_word, bank: req_bank, byte_sel: req_byte};
        r_beats <= req_len;
      end
      if (w_wd_fire) begin
        r_wdata <= wd_data;
      end
      if (w_capture) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= sram_data_out;
        r_rsp_last  <= (r_beats == '0);
      end else if (w_rsp_fire) begin
        r_rsp_valid <= 1'b0;
        r_rsp_last  <= 1'b0;
      end
      // Word address wraps within the bank; bank select never changes mid-burst.
      if ((r_state == ST_NEXT) && (r_beats != '0)) begin
        r_beats    <= r_beats - 1'b1;
        r_req.word <= r_req.word + 1'b1;
      end
    end
  end

  assign sram_word_sel = r_req.word;
  assign sram_bank_sel = r_req.bank;
  assign sram_byte_sel = r_req.byte_sel;
  assign sram_data_in  = r_wdata;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign rsp_last      = r_rsp_last;

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Self-checking bench for sram_access_sequencer with a behavioural SRAM head model
// and queue-based expected read/write results.
module tb_sram_access_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [9:0] req_word = '0;
  logic [1:0] req_bank = '0;
  logic [1:0] req_byte = '0;
  logic [3:0] req_len = '0;
  logic       wd_valid = 1'b0;
  logic       wd_ready;
  logic [7:0] wd_data = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_last;
  logic       busy;
  logic [9:0] sram_word_sel;
  logic [1:0] sram_bank_sel;
  logic [1:0] sram_byte_sel;
  logic [7:0] sram_data_in;
  logic       sram_precharge;
  logic       sram_read_en;
  logic       sram_write_en;
  logic [7:0] sram_data_out;

  always #5 clk = ~clk;

  sram_access_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_word       (req_word),
    .req_bank       (req_bank),
    .req_byte       (req_byte),
    .req_len        (req_len),
    .wd_valid       (wd_valid),
    .wd_ready       (wd_ready),
    .wd_data        (wd_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_last       (rsp_last),
    .busy           (busy),
    .sram_word_sel  (sram_word_sel),
    .sram_bank_sel  (sram_bank_sel),
    .sram_byte_sel  (sram_byte_sel),
    .sram_data_in   (sram_data_in),
    .sram_precharge (sram_precharge),
    .sram_read_en   (sram_read_en),
    .sram_write_en  (sram_write_en),
    .sram_data_out  (sram_data_out)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM head model: read data appears on the edge after each read-enable cycle.
  logic [7:0]  mem [0:16383];
  logic        pl_en = 1'b0;
  logic [13:0] pl_idx = '0;
  logic [7:0]  pl_data = '0;
  logic [7:0]  dout_r = '0;
  wire  [13:0] w_idx = {sram_bank_sel, sram_word_sel, sram_byte_sel};

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    if (sram_write_en) mem[w_idx] <= sram_data_in;
    if (sram_read_en) dout_r <= mem[w_idx];
    else dout_r <= 8'hEE;
  end
  assign sram_data_out = dout_r;

  // Pin-level monitor
  int          overlap_err = 0;
  int          stab_err = 0;
  int          act_cnt = 0;
  int          wr_cyc = 0;
  int          pre_run = 0;
  int          acc_run = 0;
  int          last_pre_len = 0;
  int          last_acc_len = 0;
  int          rsp_fire_cnt = 0;
  logic        prev_en = 1'b0;
  logic [21:0] prev_bus = '0;
  logic [13:0] last_rd_idx = '0;

  always @(negedge clk) begin
    if (sram_precharge && (sram_read_en || sram_write_en)) overlap_err++;
    if (sram_read_en && sram_write_en) overlap_err++;
    if (sram_precharge || sram_read_en || sram_write_en) act_cnt++;
    if (sram_write_en) wr_cyc++;
    if (sram_read_en) last_rd_idx = w_idx;
    if (prev_en && (sram_read_en || sram_write_en) && ({w_idx, sram_data_in} != prev_bus)) stab_err++;
    prev_en  = sram_read_en || sram_write_en;
    prev_bus = {w_idx, sram_data_in};
    if (sram_precharge) pre_run++;
    else if (pre_run != 0) begin last_pre_len = pre_run; pre_run = 0; end
    if (sram_read_en || sram_write_en) acc_run++;
    else if (acc_run != 0) begin last_acc_len = acc_run; acc_run = 0; end
    if (rsp_valid && rsp_ready) rsp_fire_cnt++;
  end

  typedef struct packed { logic [7:0] d; logic last; } exp_t;
  typedef struct packed { logic [13:0] idx; logic [7:0] d; } wexp_t;
  exp_t  exp_q[$];
  wexp_t wexp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic preload(input logic [1:0] b, input logic [9:0] w, input logic [1:0] y, input logic [7:0] d);
    pl_en = 1'b1; pl_idx = {b, w, y}; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [9:0] w, input logic [1:0] b, input logic [1:0] y,
                       input logic [3:0] len, output int acc_cyc, output logic ok);
    req_valid = 1'b1; req_write = wr; req_word = w; req_bank = b; req_byte = y; req_len = len;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin ok = 1'b1; tick(); break; end
      tick();
    end
    acc_cyc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output logic got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rsp_valid) begin got = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_idle(input int budget, output logic got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin got = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ticks(3);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got %0b expected 0", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    total++; if ({sram_precharge, sram_read_en, sram_write_en, wd_ready, rsp_valid, rsp_last} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl_outs: got %b expected 000000",
                      {sram_precharge, sram_read_en, sram_write_en, wd_ready, rsp_valid, rsp_last});
    end
    total++; if ({sram_word_sel, sram_bank_sel, sram_byte_sel, sram_data_in, rsp_data} !== 30'b0) begin
      bad++; $display("FAIL reset_data_outs: got %0h expected 0",
                      {sram_word_sel, sram_bank_sel, sram_byte_sel, sram_data_in, rsp_data});
    end
    reset_n = 1'b1;
    tick();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_req_ready: got %0b expected 1", req_ready); end
  endtask

  task automatic test_single_read();
    int acc; logic ok; logic got; int ov0; exp_t e;
    preload(2'd2, 10'd5, 2'd1, 8'hA5);
    exp_q.push_back('{d: 8'hA5, last: 1'b1});
    ov0 = overlap_err;
    rsp_ready = 1'b1;
    issue(1'b0, 10'd5, 2'd2, 2'd1, 4'd0, acc, ok);
    total++; if (!ok) begin bad++; $display("FAIL read_accept: got not accepted expected accepted"); end
    wait_rsp(20, got);
    total++; if (!got || (cyc - acc) != 6) begin
      bad++; $display("FAIL read_latency: got %0d (seen=%0b) expected 6", cyc - acc, got);
    end
    e = exp_q.pop_front();
    total++; if (rsp_data !== e.d) begin bad++; $display("FAIL read_data: got %0h expected %0h", rsp_data, e.d); end
    total++; if (rsp_last !== e.last) begin bad++; $display("FAIL read_last: got %0b expected %0b", rsp_last, e.last); end
    wait_idle(20, got);
    total++; if (last_pre_len != 2 || last_acc_len != 2) begin
      bad++; $display("FAIL read_phase_len: got pre=%0d acc=%0d expected pre=2 acc=2", last_pre_len, last_acc_len);
    end
    total++; if (last_rd_idx !== {2'd2, 10'd5, 2'd1}) begin
      bad++; $display("FAIL read_addr: got %0h expected %0h", last_rd_idx, {2'd2, 10'd5, 2'd1});
    end
    total++; if (overlap_err != ov0) begin bad++; $display("FAIL read_overlap: got %0d expected %0d", overlap_err, ov0); end
  endtask

  task automatic test_write_burst();
    int acc; logic ok; logic got; int k; int wr0; int ov0; int st0; wexp_t we;
    logic [7:0] wb [4];
    wb[0] = 8'h11; wb[1] = 8'h22; wb[2] = 8'h33; wb[3] = 8'h44;
    for (int i = 0; i < 4; i++) wexp_q.push_back('{idx: {2'd1, 10'(1022 + i), 2'd2}, d: wb[i]});
    wr0 = wr_cyc; ov0 = overlap_err; st0 = stab_err;
    wd_valid = 1'b1; wd_data = wb[0]; k = 0;
    issue(1'b1, 10'd1022, 2'd1, 2'd2, 4'd3, acc, ok);
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      if (wd_valid && wd_ready) begin
        tick(); k++;
        if (k < 4) wd_data = wb[k]; else wd_valid = 1'b0;
      end else tick();
    end
    wd_valid = 1'b0;
    total++; if (k != 4 || busy) begin bad++; $display("FAIL wburst_bytes: got %0d busy=%0b expected 4 idle", k, busy); end
    while (wexp_q.size() != 0) begin
      we = wexp_q.pop_front();
      total++; if (mem[we.idx] !== we.d) begin
        bad++; $display("FAIL wburst_mem: idx %0h got %0h expected %0h", we.idx, mem[we.idx], we.d);
      end
    end
    total++; if (wr_cyc - wr0 != 8) begin bad++; $display("FAIL wburst_we_cycles: got %0d expected 8", wr_cyc - wr0); end
    total++; if (overlap_err != ov0) begin bad++; $display("FAIL wburst_overlap: got %0d expected %0d", overlap_err, ov0); end
    total++; if (stab_err != st0) begin bad++; $display("FAIL wburst_stable: got %0d expected %0d", stab_err, st0); end
    // single write with data already offered
    wd_valid = 1'b1; wd_data = 8'h5A;
    issue(1'b1, 10'd512, 2'd0, 2'd0, 4'd0, acc, ok);
    for (int i = 0; i < 30; i++) begin
      if (!busy) break;
      if (wd_valid && wd_ready) begin tick(); wd_valid = 1'b0; end
      else tick();
    end
    wd_valid = 1'b0;
    total++; if (busy || (cyc - acc) != 6) begin
      bad++; $display("FAIL single_write_occupancy: got %0d busy=%0b expected 6", cyc - acc, busy);
    end
    total++; if (mem[{2'd0, 10'd512, 2'd0}] !== 8'h5A) begin
      bad++; $display("FAIL single_write_mem: got %0h expected 5a", mem[{2'd0, 10'd512, 2'd0}]);
    end
    wait_idle(10, got);
  endtask

  task automatic test_wd_withheld();
    int acc; logic ok; logic got; int a0;
    wd_valid = 1'b0;
    a0 = act_cnt;
    issue(1'b1, 10'd100, 2'd1, 2'd3, 4'd0, acc, ok);
    ticks(5);
    total++; if (busy !== 1'b1 || wd_ready !== 1'b1) begin
      bad++; $display("FAIL wd_hold_setup: got busy=%0b wd_ready=%0b expected 1 1", busy, wd_ready);
    end
    total++; if (act_cnt != a0) begin bad++; $display("FAIL wd_hold_no_activity: got %0d expected %0d", act_cnt - a0, 0); end
    wd_data = 8'h77; wd_valid = 1'b1;
    tick();
    wd_valid = 1'b0;
    total++; if (sram_precharge !== 1'b1) begin bad++; $display("FAIL wd_release_pre: got %0b expected 1", sram_precharge); end
    wait_idle(20, got);
    total++; if (mem[{2'd1, 10'd100, 2'd3}] !== 8'h77) begin
      bad++; $display("FAIL wd_hold_mem: got %0h expected 77", mem[{2'd1, 10'd100, 2'd3}]);
    end
  endtask

  task automatic test_read_stall();
    int acc; logic ok; logic got; int a0; logic [7:0] hold; exp_t e;
    preload(2'd3, 10'd300, 2'd0, 8'h3C);
    preload(2'd3, 10'd301, 2'd0, 8'hC3);
    exp_q.push_back('{d: 8'h3C, last: 1'b0});
    exp_q.push_back('{d: 8'hC3, last: 1'b1});
    rsp_ready = 1'b0;
    issue(1'b0, 10'd300, 2'd3, 2'd0, 4'd1, acc, ok);
    wait_rsp(20, got);
    e = exp_q.pop_front();
    total++; if (!got || rsp_data !== e.d || rsp_last !== e.last) begin
      bad++; $display("FAIL stall_beat0: got %0h last=%0b expected %0h last=%0b", rsp_data, rsp_last, e.d, e.last);
    end
    hold = rsp_data; a0 = act_cnt;
    ticks(4);
    total++; if (rsp_valid !== 1'b1 || rsp_data !== hold) begin
      bad++; $display("FAIL stall_hold: got valid=%0b data=%0h expected 1 %0h", rsp_valid, rsp_data, hold);
    end
    total++; if (act_cnt != a0) begin bad++; $display("FAIL stall_no_activity: got %0d expected 0", act_cnt - a0); end
    rsp_ready = 1'b1;
    tick();
    wait_rsp(20, got);
    e = exp_q.pop_front();
    total++; if (!got || rsp_data !== e.d || rsp_last !== e.last) begin
      bad++; $display("FAIL stall_beat1: got %0h last=%0b expected %0h last=%0b", rsp_data, rsp_last, e.d, e.last);
    end
    wait_idle(20, got);
    total++; if (last_rd_idx !== {2'd3, 10'd301, 2'd0}) begin
      bad++; $display("FAIL stall_beat1_addr: got %0h expected %0h", last_rd_idx, {2'd3, 10'd301, 2'd0});
    end
  endtask

  task automatic test_reset_mid_burst();
    int acc; logic ok; logic got; int r0; exp_t e;
    rsp_ready = 1'b1;
    issue(1'b0, 10'd10, 2'd0, 2'd0, 4'd3, acc, ok);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sram_read_en) begin got = 1'b1; break; end
      tick();
    end
    total++; if (!got) begin bad++; $display("FAIL abort_reach_acc: got no read_en expected read_en"); end
    reset_n = 1'b0;
    tick();
    total++; if ({sram_precharge, sram_read_en, sram_write_en} !== 3'b0) begin
      bad++; $display("FAIL abort_enables: got %b expected 000", {sram_precharge, sram_read_en, sram_write_en});
    end
    total++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      bad++; $display("FAIL abort_status: got busy=%0b rsp_valid=%0b req_ready=%0b expected 0 0 0", busy, rsp_valid, req_ready);
    end
    reset_n = 1'b1;
    r0 = rsp_fire_cnt;
    tick();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL abort_req_ready: got %0b expected 1", req_ready); end
    ticks(3);
    total++; if (rsp_fire_cnt != r0) begin bad++; $display("FAIL abort_no_rsp: got %0d expected 0", rsp_fire_cnt - r0); end
    preload(2'd0, 10'd6, 2'd2, 8'h5E);
    exp_q.push_back('{d: 8'h5E, last: 1'b1});
    issue(1'b0, 10'd6, 2'd0, 2'd2, 4'd0, acc, ok);
    wait_rsp(20, got);
    e = exp_q.pop_front();
    total++; if (!got || (cyc - acc) != 6 || rsp_data !== e.d || rsp_last !== e.last) begin
      bad++; $display("FAIL abort_new_read: got lat=%0d data=%0h last=%0b expected lat=6 data=%0h last=%0b",
                      cyc - acc, rsp_data, rsp_last, e.d, e.last);
    end
    wait_idle(20, got);
  endtask

  task automatic test_busy_reject();
    int acc; logic ok; logic got; int viol; logic seen; logic [7:0] r1; exp_t e;
    preload(2'd0, 10'd20, 2'd1, 8'h20);
    preload(2'd0, 10'd21, 2'd1, 8'h21);
    exp_q.push_back('{d: 8'h20, last: 1'b1});
    exp_q.push_back('{d: 8'h21, last: 1'b1});
    rsp_ready = 1'b1;
    issue(1'b0, 10'd20, 2'd0, 2'd1, 4'd0, acc, ok);
    req_valid = 1'b1; req_write = 1'b0; req_word = 10'd21; req_bank = 2'd0; req_byte = 2'd1; req_len = 4'd0;
    viol = 0; seen = 1'b0; r1 = '0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      if (req_ready) viol++;
      if (rsp_valid && !seen) begin seen = 1'b1; r1 = rsp_data; end
      tick();
    end
    total++; if (viol != 0) begin bad++; $display("FAIL busy_req_ready: got %0d ready cycles expected 0", viol); end
    e = exp_q.pop_front();
    total++; if (!seen || r1 !== e.d) begin bad++; $display("FAIL busy_first_rsp: got %0h seen=%0b expected %0h", r1, seen, e.d); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL busy_first_idle_ready: got %0b expected 1", req_ready); end
    tick();
    acc = cyc;
    req_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_second_accept: got %0b expected 1", busy); end
    wait_rsp(20, got);
    e = exp_q.pop_front();
    total++; if (!got || (cyc - acc) != 6 || rsp_data !== e.d) begin
      bad++; $display("FAIL busy_second_rsp: got lat=%0d data=%0h expected lat=6 data=%0h", cyc - acc, rsp_data, e.d);
    end
    wait_idle(20, got);
  endtask

  task automatic test_back_to_back();
    int acc; logic ok; int n; exp_t e;
    logic [7:0] wb [4];
    wb[0] = 8'h11; wb[1] = 8'h22; wb[2] = 8'h33; wb[3] = 8'h44;
    for (int i = 0; i < 4; i++) exp_q.push_back('{d: wb[i], last: (i == 3)});
    rsp_ready = 1'b1;
    issue(1'b0, 10'd1022, 2'd1, 2'd2, 4'd3, acc, ok);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      rsp_ready = 1'($urandom_range(0, 1));
      if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n++;
        total++; if (rsp_data !== e.d || rsp_last !== e.last) begin
          bad++; $display("FAIL b2b_beat%0d: got %0h last=%0b expected %0h last=%0b", n - 1, rsp_data, rsp_last, e.d, e.last);
        end
      end
      tick();
    end
    total++; if (n != 4 || busy) begin bad++; $display("FAIL b2b_beat_count: got %0d busy=%0b expected 4 idle", n, busy); end
    rsp_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_burst();
    test_wd_withheld();
    test_read_stall();
    test_reset_mid_burst();
    test_busy_reject();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
